ysyx_23060025_rd_arbiter: RTL and testbench

//   Two-master AXI4 read-channel arbiter between IFU instruction fetch and LSU load

---
 rtl/ysyx_23060025_rd_arbiter.sv | 170 +++++++++++++++++
 tb/tb_ysyx_23060025_rd_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060025_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter (IFU fetch vs LSU load) onto one AR/R pair.
// Round-robin grant. Ownership is held from the grant until the rlast beat.
// Single-beat transfers only.
//
// Handshake semantics: a transfer happens on a rising clock edge where valid and
// ready are both 1. Valid never waits on ready. Once the downstream arvalid is
// raised, it and its payload stay stable until arready is seen.
module ysyx_23060025_rd_arbiter #(
  parameter int          ADDR_LEN = 32,
  parameter int          DATA_LEN = 32,
  parameter logic [3:0]  INST_ID  = 4'd0,
  parameter logic [3:0]  DATA_ID  = 4'd1
) (
  input  logic                clock,
  input  logic                rstn,
  input  logic [ADDR_LEN-1:0] inst_ar_addr_i,
  input  logic                inst_ar_valid_i,
  output logic                inst_ar_ready_o,
  output logic [DATA_LEN-1:0] inst_r_data_o,
  output logic [1:0]          inst_r_resp_o,
  output logic                inst_r_valid_o,
  input  logic                inst_r_ready_i,
  input  logic [ADDR_LEN-1:0] data_ar_addr_i,
  input  logic [2:0]          data_ar_size_i,
  input  logic                data_ar_valid_i,
  output logic                data_ar_ready_o,
  output logic [DATA_LEN-1:0] data_r_data_o,
  output logic [1:0]          data_r_resp_o,
  output logic                data_r_valid_o,
  input  logic                data_r_ready_i,
  output logic [ADDR_LEN-1:0] axi_ar_addr_o,
  output logic                axi_ar_valid_o,
  input  logic                axi_ar_ready_i,
  output logic [3:0]          axi_ar_id_o,
  output logic [7:0]          axi_ar_len_o,
  output logic [2:0]          axi_ar_size_o,
  output logic [1:0]          axi_ar_burst_o,
  input  logic [DATA_LEN-1:0] axi_r_data_i,
  input  logic [1:0]          axi_r_resp_i,
  input  logic                axi_r_valid_i,
  input  logic                axi_r_last_i,
  output logic                axi_r_ready_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2
  } state_e;

  // Master select encoding used by owner and last_grant.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                last_grant_q, last_grant_d;
  logic [ADDR_LEN-1:0] ar_addr_q, ar_addr_d;
  logic [3:0]          ar_id_q, ar_id_d;
  logic [2:0]          ar_size_q, ar_size_d;

  logic grant_inst;
  logic grant_data;
  logic in_r;

  // Round-robin pick in IDLE; on a contest the master that did not win last time wins.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (rstn && (state_q == S_IDLE)) begin
      if (inst_ar_valid_i && data_ar_valid_i) begin
        if (last_grant_q == OWN_DATA) grant_inst = 1'b1;
        else                          grant_data = 1'b1;
      end else begin
        grant_inst = inst_ar_valid_i;
        grant_data = data_ar_valid_i;
      end
    end
  end

  // State register plus the latched request fields.
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state_q      <= S_IDLE;
      owner_q      <= OWN_INST;
      last_grant_q <= OWN_DATA;
      ar_addr_q    <= '0;
      ar_id_q      <= '0;
      ar_size_q    <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      ar_addr_q    <= ar_addr_d;
      ar_id_q      <= ar_id_d;
      ar_size_q    <= ar_size_d;
    end
  end

  // Next state. The request is captured on the grant cycle so later input changes are ignored.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    ar_addr_d    = ar_addr_q;
    ar_id_d      = ar_id_q;
    ar_size_d    = ar_size_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_inst) begin
          state_d      = S_AR;
          owner_d      = OWN_INST;
          last_grant_d = OWN_INST;
          ar_addr_d    = inst_ar_addr_i;
          ar_id_d      = INST_ID;
          ar_size_d    = 3'b010;
        end else if (grant_data) begin
          state_d      = S_AR;
          owner_d      = OWN_DATA;
          last_grant_d = OWN_DATA;
          ar_addr_d    = data_ar_addr_i;
          ar_id_d      = DATA_ID;
          ar_size_d    = data_ar_size_i;
        end
      end
      S_AR: begin
        if (axi_ar_ready_i) state_d = S_R;
      end
      S_R: begin
        // A non-last beat is forwarded but ownership is kept.
        if (axi_r_valid_i && axi_r_ready_o && axi_r_last_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs. Valid/ready are forced low while reset is asserted; R is routed to the owner only.
  always_comb begin
    in_r            = rstn && (state_q == S_R);
    inst_ar_ready_o = grant_inst;
    data_ar_ready_o = grant_data;
    axi_ar_valid_o  = rstn && (state_q == S_AR);
    axi_ar_addr_o   = ar_addr_q;
    axi_ar_id_o     = ar_id_q;
    axi_ar_size_o   = ar_size_q;
    axi_ar_len_o    = 8'd0;
    axi_ar_burst_o  = 2'b01;
    axi_r_ready_o   = 1'b0;
    inst_r_valid_o  = 1'b0;
    inst_r_data_o   = '0;
    inst_r_resp_o   = 2'b00;
    data_r_valid_o  = 1'b0;
    data_r_data_o   = '0;
    data_r_resp_o   = 2'b00;
    if (in_r) begin
      if (owner_q == OWN_INST) begin
        axi_r_ready_o  = inst_r_ready_i;
        inst_r_valid_o = axi_r_valid_i;
        inst_r_data_o  = axi_r_data_i;
        inst_r_resp_o  = axi_r_resp_i;
      end else begin
        axi_r_ready_o  = data_r_ready_i;
        data_r_valid_o = axi_r_valid_i;
        data_r_data_o  = axi_r_data_i;
        data_r_resp_o  = axi_r_resp_i;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_23060025_rd_arbiter.sv
// Bench for the two-master read arbiter: a downstream slave is emulated by driver
// code, and grants/routing are predicted by a round-robin reference model.
module tb_ysyx_23060025_rd_arbiter;

  logic        clock;
  logic        rstn;
  logic [31:0] inst_ar_addr;
  logic        inst_ar_valid;
  logic        inst_ar_ready_o;
  logic [31:0] inst_r_data_o;
  logic [1:0]  inst_r_resp_o;
  logic        inst_r_valid_o;
  logic        inst_r_ready;
  logic [31:0] data_ar_addr;
  logic [2:0]  data_ar_size;
  logic        data_ar_valid;
  logic        data_ar_ready_o;
  logic [31:0] data_r_data_o;
  logic [1:0]  data_r_resp_o;
  logic        data_r_valid_o;
  logic        data_r_ready;
  logic [31:0] axi_ar_addr_o;
  logic        axi_ar_valid_o;
  logic        axi_ar_ready;
  logic [3:0]  axi_ar_id_o;
  logic [7:0]  axi_ar_len_o;
  logic [2:0]  axi_ar_size_o;
  logic [1:0]  axi_ar_burst_o;
  logic [31:0] axi_r_data;
  logic [1:0]  axi_r_resp;
  logic        axi_r_valid;
  logic        axi_r_last;
  logic        axi_r_ready_o;

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: which master won the most recent grant (0 = IFU, 1 = LSU).
  logic       model_last;
  logic [3:0] exp_q[$];
  logic [3:0] seen_id;

  ysyx_23060025_rd_arbiter dut (
    .clock(clock), .rstn(rstn),
    .inst_ar_addr_i(inst_ar_addr), .inst_ar_valid_i(inst_ar_valid), .inst_ar_ready_o(inst_ar_ready_o),
    .inst_r_data_o(inst_r_data_o), .inst_r_resp_o(inst_r_resp_o), .inst_r_valid_o(inst_r_valid_o),
    .inst_r_ready_i(inst_r_ready),
    .data_ar_addr_i(data_ar_addr), .data_ar_size_i(data_ar_size), .data_ar_valid_i(data_ar_valid),
    .data_ar_ready_o(data_ar_ready_o),
    .data_r_data_o(data_r_data_o), .data_r_resp_o(data_r_resp_o), .data_r_valid_o(data_r_valid_o),
    .data_r_ready_i(data_r_ready),
    .axi_ar_addr_o(axi_ar_addr_o), .axi_ar_valid_o(axi_ar_valid_o), .axi_ar_ready_i(axi_ar_ready),
    .axi_ar_id_o(axi_ar_id_o), .axi_ar_len_o(axi_ar_len_o), .axi_ar_size_o(axi_ar_size_o),
    .axi_ar_burst_o(axi_ar_burst_o),
    .axi_r_data_i(axi_r_data), .axi_r_resp_i(axi_r_resp), .axi_r_valid_i(axi_r_valid),
    .axi_r_last_i(axi_r_last), .axi_r_ready_o(axi_r_ready_o)
  );

  // Clock and reset block.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Drivers act 1 time unit after the rising edge; checks happen 4 units after it.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    inst_ar_addr  = '0;
    inst_ar_valid = 1'b0;
    inst_r_ready  = 1'b0;
    data_ar_addr  = '0;
    data_ar_size  = '0;
    data_ar_valid = 1'b0;
    data_r_ready  = 1'b0;
    axi_ar_ready  = 1'b0;
    axi_r_data    = '0;
    axi_r_resp    = '0;
    axi_r_valid   = 1'b0;
    axi_r_last    = 1'b0;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    clear_inputs();
    repeat (2) next_cycle();
    rstn = 1'b1;
    model_last = 1'b1;
  endtask

  // Round-robin rule: a lone requester wins; on a contest the one that did not win last time wins.
  function automatic logic pick(input logic iv, input logic dv);
    if (iv && dv) return ~model_last;
    return dv;
  endfunction

  // One complete transaction: grant, AR phase (with stalls and stray rvalid), R phase.
  task automatic run_txn(input logic iv, input logic dv, input logic [31:0] iaddr,
                         input logic [31:0] daddr, input logic [2:0] dsize, input int ar_wait,
                         input int r_wait, input logic extra, input logic [31:0] rdata,
                         input logic [1:0] rresp);
    logic        win;
    logic [31:0] e_addr;
    logic [3:0]  e_id;
    logic [2:0]  e_size;
    logic        rr;
    logic [31:0] bdata;
    int          beats;
    inst_ar_valid = iv;
    inst_ar_addr  = iaddr;
    data_ar_valid = dv;
    data_ar_addr  = daddr;
    data_ar_size  = dsize;
    #3;
    win    = pick(iv, dv);
    e_addr = win ? daddr : iaddr;
    e_id   = win ? 4'd1 : 4'd0;
    e_size = win ? dsize : 3'd2;
    vectors++;
    if ({inst_ar_ready_o, data_ar_ready_o} !== {~win, win}) begin
      miscompares++;
      $display("FAIL grant: ready inst/data=%b%b expected %b%b", inst_ar_ready_o, data_ar_ready_o, ~win, win);
    end
    model_last = win;
    next_cycle();
    for (int c = 0; c <= ar_wait; c++) begin
      inst_ar_addr = $urandom;
      data_ar_addr = $urandom;
      data_ar_size = 3'($urandom_range(0, 2));
      axi_ar_ready = (c == ar_wait);
      axi_r_valid  = (c != ar_wait);
      axi_r_last   = 1'b1;
      inst_r_ready = 1'b1;
      data_r_ready = 1'b1;
      #3;
      vectors++;
      if (axi_ar_valid_o !== 1'b1 || axi_ar_addr_o !== e_addr || axi_ar_id_o !== e_id ||
          axi_ar_size_o !== e_size || axi_ar_len_o !== 8'd0 || axi_ar_burst_o !== 2'b01) begin
        miscompares++;
        $display("FAIL ar_fields: valid=%b addr=%h id=%0d size=%0d len=%0d burst=%0d expected 1 %h %0d %0d 0 1",
                 axi_ar_valid_o, axi_ar_addr_o, axi_ar_id_o, axi_ar_size_o, axi_ar_len_o, axi_ar_burst_o,
                 e_addr, e_id, e_size);
      end
      vectors++;
      if ({axi_r_ready_o, inst_r_valid_o, data_r_valid_o, inst_ar_ready_o, data_ar_ready_o} !== 5'b0) begin
        miscompares++;
        $display("FAIL ar_quiet: rready=%b ivalid=%b dvalid=%b iarr=%b darr=%b expected all 0",
                 axi_r_ready_o, inst_r_valid_o, data_r_valid_o, inst_ar_ready_o, data_ar_ready_o);
      end
      seen_id = axi_ar_id_o;
      next_cycle();
    end
    axi_ar_ready = 1'b0;
    beats = extra ? 2 : 1;
    for (int b = 0; b < beats; b++) begin
      for (int c = 0; c <= r_wait; c++) begin
        rr          = (c == r_wait);
        bdata       = (b == beats - 1) ? rdata : ~rdata;
        axi_r_valid = 1'b1;
        axi_r_data  = bdata;
        axi_r_resp  = rresp;
        axi_r_last  = (b == beats - 1);
        inst_r_ready = win ? 1'b1 : rr;
        data_r_ready = win ? rr : 1'b1;
        #3;
        vectors++;
        if (axi_r_ready_o !== rr) begin
          miscompares++;
          $display("FAIL r_ready: axi_r_ready=%b expected %b", axi_r_ready_o, rr);
        end
        vectors++;
        if (win ? ({data_r_valid_o, data_r_data_o, data_r_resp_o} !== {1'b1, bdata, rresp} ||
                   {inst_r_valid_o, inst_r_data_o, inst_r_resp_o} !== 35'b0)
                : ({inst_r_valid_o, inst_r_data_o, inst_r_resp_o} !== {1'b1, bdata, rresp} ||
                   {data_r_valid_o, data_r_data_o, data_r_resp_o} !== 35'b0)) begin
          miscompares++;
          $display("FAIL r_route: inst v=%b d=%h r=%0d data v=%b d=%h r=%0d expected owner=%0d d=%h r=%0d",
                   inst_r_valid_o, inst_r_data_o, inst_r_resp_o, data_r_valid_o, data_r_data_o,
                   data_r_resp_o, win, bdata, rresp);
        end
        next_cycle();
      end
    end
    clear_inputs();
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    clear_inputs();
    next_cycle();
    inst_ar_valid = 1'b1;
    data_ar_valid = 1'b1;
    axi_r_valid   = 1'b1;
    axi_ar_ready  = 1'b1;
    inst_r_ready  = 1'b1;
    data_r_ready  = 1'b1;
    #3;
    vectors++;
    if ({inst_ar_ready_o, data_ar_ready_o, axi_ar_valid_o, axi_r_ready_o, inst_r_valid_o, data_r_valid_o} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_handshake: iarr=%b darr=%b arvalid=%b rready=%b ivalid=%b dvalid=%b expected all 0",
               inst_ar_ready_o, data_ar_ready_o, axi_ar_valid_o, axi_r_ready_o, inst_r_valid_o, data_r_valid_o);
    end
    vectors++;
    if ({axi_ar_addr_o, axi_ar_id_o, axi_ar_size_o} !== 39'b0) begin
      miscompares++;
      $display("FAIL reset_ar_regs: addr=%h id=%0d size=%0d expected 0", axi_ar_addr_o, axi_ar_id_o, axi_ar_size_o);
    end
    next_cycle();
    clear_inputs();
    rstn = 1'b1;
    model_last = 1'b1;
    next_cycle();
    axi_r_valid  = 1'b1;
    axi_r_last   = 1'b1;
    inst_r_ready = 1'b1;
    data_r_ready = 1'b1;
    #3;
    vectors++;
    if ({axi_r_ready_o, inst_r_valid_o, data_r_valid_o, axi_ar_valid_o} !== 4'b0) begin
      miscompares++;
      $display("FAIL idle_stray_r: rready=%b ivalid=%b dvalid=%b arvalid=%b expected all 0",
               axi_r_ready_o, inst_r_valid_o, data_r_valid_o, axi_ar_valid_o);
    end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_inst_only();
    run_txn(1'b1, 1'b0, 32'h3000_0000, 32'h0, 3'd0, 0, 0, 1'b0, 32'hDEAD_BEEF, 2'b00);
    #3;
    vectors++;
    if ({axi_ar_valid_o, axi_r_ready_o, inst_r_valid_o} !== 3'b0) begin
      miscompares++;
      $display("FAIL back_to_idle: arvalid=%b rready=%b ivalid=%b expected 0", axi_ar_valid_o, axi_r_ready_o, inst_r_valid_o);
    end
    next_cycle();
  endtask

  task automatic test_both_first();
    apply_reset();
    run_txn(1'b1, 1'b1, 32'h8000_0100, 32'h0F00_0010, 3'd0, 0, 0, 1'b0, $urandom, 2'b00);
    vectors++;
    if (seen_id !== 4'd0) begin
      miscompares++;
      $display("FAIL first_contest: arid=%0d expected 0", seen_id);
    end
    run_txn(1'b0, 1'b1, 32'h0, 32'h0F00_0010, 3'd0, 0, 0, 1'b0, $urandom, 2'b00);
    vectors++;
    if (seen_id !== 4'd1) begin
      miscompares++;
      $display("FAIL lsu_after: arid=%0d expected 1", seen_id);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) exp_q.push_back((i % 2 == 0) ? 4'd0 : 4'd1);
    for (int i = 0; i < 6; i++) begin
      run_txn(1'b1, 1'b1, $urandom, $urandom, 3'($urandom_range(0, 2)), $urandom_range(0, 1),
              $urandom_range(0, 1), 1'b0, $urandom, 2'($urandom_range(0, 3)));
      vectors++;
      if (seen_id !== exp_q[0]) begin
        miscompares++;
        $display("FAIL alternate[%0d]: arid=%0d expected %0d", i, seen_id, exp_q[0]);
      end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_ar_stall();
    run_txn(1'b1, 1'b0, 32'h3000_0040, 32'h0, 3'd0, 5, 0, 1'b0, 32'h1234_5678, 2'b00);
  endtask

  task automatic test_r_stall();
    run_txn(1'b0, 1'b1, 32'h0, 32'h0F00_0020, 3'd1, 0, 3, 1'b0, 32'hCAFE_F00D, 2'b10);
    run_txn(1'b1, 1'b0, 32'h3000_0080, 32'h0, 3'd0, 1, 3, 1'b1, 32'hA5A5_5A5A, 2'b10);
  endtask

  task automatic test_random();
    logic iv, dv;
    for (int i = 0; i < 24; i++) begin
      iv = 1'($urandom_range(0, 1));
      dv = iv ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn(iv, dv, $urandom, $urandom, 3'($urandom_range(0, 2)), $urandom_range(0, 3),
              $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_reset_in_r();
    inst_ar_valid = 1'b1;
    inst_ar_addr  = 32'h3000_0100;
    data_ar_valid = 1'b0;
    next_cycle();
    inst_ar_valid = 1'b0;
    axi_ar_ready  = 1'b1;
    next_cycle();
    axi_ar_ready = 1'b0;
    axi_r_valid  = 1'b1;
    axi_r_last   = 1'b1;
    axi_r_data   = 32'h5555_AAAA;
    inst_r_ready = 1'b1;
    #2;
    vectors++;
    if (inst_r_valid_o !== 1'b1 || axi_r_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_r: ivalid=%b rready=%b expected 1 1", inst_r_valid_o, axi_r_ready_o);
    end
    rstn = 1'b0;
    #1;
    vectors++;
    if ({inst_r_valid_o, data_r_valid_o, axi_r_ready_o, axi_ar_valid_o, inst_r_data_o} !== 36'b0) begin
      miscompares++;
      $display("FAIL reset_in_r: ivalid=%b dvalid=%b rready=%b arvalid=%b idata=%h expected all 0",
               inst_r_valid_o, data_r_valid_o, axi_r_ready_o, axi_ar_valid_o, inst_r_data_o);
    end
    next_cycle();
    clear_inputs();
    rstn = 1'b1;
    model_last = 1'b1;
    next_cycle();
    run_txn(1'b1, 1'b1, 32'h3000_0200, 32'h0F00_0030, 3'd2, 0, 0, 1'b0, $urandom, 2'b00);
    vectors++;
    if (seen_id !== 4'd0) begin
      miscompares++;
      $display("FAIL contest_after_reset: arid=%0d expected 0", seen_id);
    end
  endtask

  initial begin
    model_last = 1'b1;
    seen_id    = '0;
    test_reset();
    test_inst_only();
    test_both_first();
    test_back_to_back();
    test_ar_stall();
    test_r_stall();
    test_random();
    test_reset_in_r();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
